// File: rtl/lif_neuron_integrator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lif_neuron_integrator_if                                           |
// | Synaptic input stream and spike result bundle for the LIF neuron.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface lif_neuron_integrator_if #(
   parameter int IN_WIDTH = 12
);
   logic                in_valid;
   logic                in_ready;
   logic [IN_WIDTH-1:0] in_sum;
   logic                spike_out;
   logic                spike_valid;

   modport master (
      output in_valid,
      output in_sum,
      input  in_ready,
      input  spike_out,
      input  spike_valid
   );

   modport slave (
      input  in_valid,
      input  in_sum,
      output in_ready,
      output spike_out,
      output spike_valid
   );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_integrator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lif_neuron_integrator                                              |
// | Leaky integrate-and-fire membrane over T_STEPS timesteps/sample.   |
// | Macro LIF_SOFT_RESET_EN selects subtractive post-fire reset.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lif_neuron_integrator #(
   parameter int IN_WIDTH = 12,
   parameter int V_WIDTH  = 16,
   parameter int T_STEPS  = 8
) (
   input  wire                   clk,
   input  wire                   rst,
   input  wire                   start,
   input  wire   [V_WIDTH-1:0]   threshold,
   input  wire   [3:0]           leak_shift,
   output logic  [7:0]           spike_cnt,
   output logic                  busy,
   output logic                  done,
   lif_neuron_integrator_if.slave bus
);

   localparam int SUM_W = ((IN_WIDTH > V_WIDTH) ? IN_WIDTH : V_WIDTH) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] INTEG = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state_q,       state_d;
   logic [V_WIDTH-1:0] v_q,           v_d;
   logic [7:0]         step_q,        step_d;
   logic [7:0]         spike_cnt_q,   spike_cnt_d;
   logic [V_WIDTH-1:0] thr_q,         thr_d;
   logic [3:0]         leak_q,        leak_d;
   logic               spike_out_q,   spike_out_d;
   logic               spike_valid_q, spike_valid_d;

   logic               w_xfer;
   logic               w_last;
   logic [V_WIDTH-1:0] w_v_leak;
   logic [SUM_W-1:0]   w_sum_wide;
   logic               w_sat;
   logic [V_WIDTH-1:0] w_v_sum;
   logic               w_fire;
   logic [V_WIDTH-1:0] w_v_post_fire;

   assign w_xfer = (state_q == INTEG) && bus.in_valid;
   assign w_last = (step_q == 8'(T_STEPS - 1));

   // Shift-based leak: v decays by v/2^leak_shift each accepted step.
   assign w_v_leak   = (leak_q == 4'd0) ? v_q : (v_q - (v_q >> leak_q));
   assign w_sum_wide = {{(SUM_W-V_WIDTH){1'b0}}, w_v_leak}
                     + {{(SUM_W-IN_WIDTH){1'b0}}, bus.in_sum};
   assign w_sat      = |w_sum_wide[SUM_W-1:V_WIDTH];
   assign w_v_sum    = w_sat ? {V_WIDTH{1'b1}} : w_sum_wide[V_WIDTH-1:0];
   assign w_fire     = (w_v_sum >= thr_q);

`ifdef LIF_SOFT_RESET_EN
   // Fire implies w_v_sum >= thr_q, so this cannot underflow.
   assign w_v_post_fire = w_v_sum - thr_q;
`else
   assign w_v_post_fire = '0;
`endif

   always_comb begin
      state_d       = state_q;
      v_d           = v_q;
      step_d        = step_q;
      spike_cnt_d   = spike_cnt_q;
      thr_d         = thr_q;
      leak_d        = leak_q;
      spike_out_d   = spike_out_q;
      spike_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = INTEG;
               v_d         = '0;
               step_d      = '0;
               spike_cnt_d = '0;
               thr_d       = threshold;
               leak_d      = leak_shift;
            end
         end
         INTEG: begin
            if (w_xfer) begin
               spike_valid_d = 1'b1;
               spike_out_d   = w_fire;
               step_d        = step_q + 8'd1;
               if (w_fire) begin
                  v_d         = w_v_post_fire;
                  spike_cnt_d = spike_cnt_q + 8'd1;
               end else begin
                  v_d = w_v_sum;
               end
               if (w_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         v_q           <= '0;
         step_q        <= '0;
         spike_cnt_q   <= '0;
         thr_q         <= '0;
         leak_q        <= '0;
         spike_out_q   <= 1'b0;
         spike_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         v_q           <= v_d;
         step_q        <= step_d;
         spike_cnt_q   <= spike_cnt_d;
         thr_q         <= thr_d;
         leak_q        <= leak_d;
         spike_out_q   <= spike_out_d;
         spike_valid_q <= spike_valid_d;
      end
   end

   assign bus.in_ready    = (state_q == INTEG);
   assign bus.spike_out   = spike_out_q;
   assign bus.spike_valid = spike_valid_q;
   assign spike_cnt       = spike_cnt_q;
   assign busy            = (state_q != IDLE);
   assign done            = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_integrator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lif_neuron_integrator                                           |
// | Scoreboard bench: model pushes expected spikes, monitor pops them. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lif_neuron_integrator;

   localparam int IN_W = 8;
   localparam int V_W  = 8;
   localparam int T    = 4;

   logic           clk        = 1'b0;
   logic           rst        = 1'b0;
   logic           start      = 1'b0;
   logic [V_W-1:0] threshold  = '0;
   logic [3:0]     leak_shift = '0;
   logic [7:0]     spike_cnt;
   logic           busy;
   logic           done;

   lif_neuron_integrator_if #(.IN_WIDTH(IN_W)) bus ();

   lif_neuron_integrator #(
      .IN_WIDTH (IN_W),
      .V_WIDTH  (V_W),
      .T_STEPS  (T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .threshold  (threshold),
      .leak_shift (leak_shift),
      .spike_cnt  (spike_cnt),
      .busy       (busy),
      .done       (done),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       spk;
      logic [7:0] cnt;
      logic       last;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   done_seen = 0;
   int   stim[T];
   int   gap[T];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.spike_valid) begin
         if (q.size() == 0) begin
            check("spike_valid_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check("spike_out", {31'd0, bus.spike_out}, {31'd0, mon_e.spk});
            check("spike_cnt", {24'd0, spike_cnt}, {24'd0, mon_e.cnt});
            check("done_on_last", {31'd0, done}, {31'd0, mon_e.last});
         end
      end else if (done) begin
         check("done_without_valid", 32'd1, 32'd0);
      end
      if (done) done_seen++;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},    {31'd0, bus.in_ready},    32'd0);
      check({tag, "_spike_out"},   {31'd0, bus.spike_out},   32'd0);
      check({tag, "_spike_valid"}, {31'd0, bus.spike_valid}, 32'd0);
      check({tag, "_spike_cnt"},   {24'd0, spike_cnt},       32'd0);
      check({tag, "_busy"},        {31'd0, busy},            32'd0);
      check({tag, "_done"},        {31'd0, done},            32'd0);
   endtask

   // abort_after > 0 asserts rst after that many transfers.
   task automatic run_sample(input int thr, input int ls, input int abort_after);
      int mv, mcnt, vl, vs, d0;
      bit spk;
      @(posedge clk); #1;
      threshold  = thr[V_W-1:0];
      leak_shift = ls[3:0];
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      d0   = done_seen;
      mv   = 0;
      mcnt = 0;
      for (int i = 0; i < T; i++) begin
         for (int g = 0; g < gap[i]; g++) begin
            bus.in_valid = 1'b0;
            start        = (g == 0);
            check("busy_in_gap", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            start = 1'b0;
         end
         check("in_ready", {31'd0, bus.in_ready}, 32'd1);
         vl = (ls == 0) ? mv : mv - (mv >> ls);
         vs = vl + stim[i];
         if (vs > 255) vs = 255;
         spk = (vs >= thr);
         if (spk) begin
            mcnt++;
`ifdef LIF_SOFT_RESET_EN
            mv = vs - thr;
`else
            mv = 0;
`endif
         end else begin
            mv = vs;
         end
         q.push_back('{spk: spk, cnt: mcnt[7:0], last: (i == T-1)});
         bus.in_valid = 1'b1;
         bus.in_sum   = stim[i][IN_W-1:0];
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (abort_after == i + 1) begin
            @(negedge clk); #1;
            rst = 1'b1;
            #1;
            check_all_zero("abort");
            check("abort_no_done", done_seen - d0, 32'd0);
            check("abort_queue_empty", q.size(), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
      end
      @(negedge clk);
      @(posedge clk); #1;
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("final_spike_cnt", {24'd0, spike_cnt}, mcnt);
      check("done_pulses", done_seen - d0, 32'd1);
      check("queue_drained", q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("spike_cnt_hold", {24'd0, spike_cnt}, mcnt);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sum   = '0;
      #1 rst = 1'b1;
      #2;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic integrate/fire, no leak.
      stim = '{6, 6, 6, 6};
      gap  = '{0, 0, 0, 0};
      run_sample(10, 0, 0);
      check("basic_cnt", {24'd0, spike_cnt}, 32'd2);

      // Leak by half each step, never reaching threshold.
      stim = '{40, 40, 40, 40};
      run_sample(100, 1, 0);
      check("leak_cnt", {24'd0, spike_cnt}, 32'd0);

      // Sum above 8-bit range saturates and reaches threshold 255.
      stim = '{200, 200, 200, 200};
      run_sample(255, 0, 0);
      check("sat_cnt", {24'd0, spike_cnt}, 32'd2);

      // in_valid while idle must be ignored.
      bus.in_valid = 1'b1;
      bus.in_sum   = 8'd50;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("idle_busy", {31'd0, busy}, 32'd0);
      end
      bus.in_valid = 1'b0;

      // Backpressure gaps with stray start pulses.
      stim = '{3, 9, 1, 20};
      gap  = '{1, 2, 0, 3};
      run_sample(10, 2, 0);

      // Zero threshold fires every step.
      stim = '{0, 5, 0, 7};
      gap  = '{0, 0, 0, 0};
      run_sample(0, 0, 0);
      check("thr0_cnt", {24'd0, spike_cnt}, 32'd4);

      // Abort mid-sample, then a clean sample.
      stim = '{6, 6, 6, 6};
      run_sample(10, 0, 2);
      @(posedge clk); #1;
      check_all_zero("post_abort");
      stim = '{30, 1, 90, 14};
      gap  = '{0, 1, 0, 0};
      run_sample(50, 3, 0);

      // Large leak shift with random inputs.
      for (int i = 0; i < T; i++) stim[i] = $urandom_range(0, 255);
      gap = '{0, 0, 1, 0};
      run_sample($urandom_range(1, 255), 15, 0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lif_neuron_integrator.md
LIF_NEURON_INTEGRATOR -- requirements
Module: lif_neuron_integrator

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 12, giving the width of the unsigned synaptic sum from the upstream adder tree.
REQ-002 The block SHALL have parameter V_WIDTH, default 16, giving the width of the unsigned membrane potential.
REQ-003 The block SHALL have parameter T_STEPS, default 8, giving the number of timesteps per sample (range 1..255).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port start, input, 1 bit: begins a new sample when the block is idle.
REQ-007 Port in_valid, input, 1 bit: in_sum is valid.
REQ-008 Port in_ready, output, 1 bit: the block accepts in_sum this cycle.
REQ-009 Port in_sum, input, IN_WIDTH bits: the summed weighted spikes for the current timestep.
REQ-010 Port threshold, input, V_WIDTH bits: the firing threshold, sampled at start.
REQ-011 Port leak_shift, input, 4 bits: the leak shift amount, sampled at start; value 0 means no leak.
REQ-012 Port spike_out, output, 1 bit: the spike result for the last accepted timestep.
REQ-013 Port spike_valid, output, 1 bit: spike_out is valid this cycle.
REQ-014 Port spike_cnt, output, 8 bits: the number of spikes in the current or most recent sample.
REQ-015 Port busy, output, 1 bit: a sample is in progress.
REQ-016 Port done, output, 1 bit: one-cycle pulse marking the end of a sample.

Function
REQ-017 The FSM SHALL have three states, IDLE, INTEG and DONE, with the following transitions:
- IDLE to INTEG on start.
- INTEG to DONE on acceptance of the T_STEPS-th input.
- DONE to IDLE unconditionally after one cycle.
REQ-018 When IDLE sees start, the block SHALL clear v, the timestep counter and spike_cnt, and latch threshold and leak_shift.
REQ-019 in_ready SHALL be 1 only in INTEG; a transfer occurs when in_valid and in_ready are both 1.
REQ-020 On each transfer the block SHALL compute the membrane update as follows:
- v_leak = v - (v >> leak_shift) when leak_shift is nonzero, and v_leak = v when leak_shift is 0.
- v_sum = v_leak + in_sum, computed at V_WIDTH+1 bits and saturated to 2^V_WIDTH-1.
REQ-021 If v_sum >= threshold, the block SHALL fire (spike_out=1, spike_cnt+1) and apply the post-fire potential defined under Configuration.
REQ-022 If v_sum < threshold, the block SHALL set v = v_sum and spike_out = 0.
REQ-023 spike_out and spike_valid SHALL be registered: spike_valid is high exactly the one cycle after each transfer and 0 otherwise.
REQ-024 done SHALL be high for the single cycle spent in DONE, which coincides with spike_valid for the last timestep.
REQ-025 spike_cnt SHALL hold its value after DONE until the next accepted start.
REQ-026 busy SHALL be 1 in INTEG and DONE.
REQ-027 start SHALL be ignored in INTEG and DONE.
REQ-028 in_valid SHALL be ignored outside INTEG.
REQ-029 In INTEG with in_valid=0, v and the timestep counter SHALL hold.
REQ-030 threshold=0 SHALL cause a fire on every timestep.
REQ-031 spike_cnt SHALL NOT wrap, since T_STEPS <= 255.

Reset
REQ-032 While rst=1, the block SHALL asynchronously force the FSM to IDLE and clear v, the timestep counter, spike_cnt, the latched threshold and the latched leak_shift to 0.
REQ-033 While rst=1, all outputs (in_ready, spike_out, spike_valid, spike_cnt, busy, done) SHALL be 0.
REQ-034 Reset asserted mid-sample SHALL abandon the sample with no done pulse.

Configuration
REQ-035 The block SHALL support macro LIF_SOFT_RESET_EN, with post-fire behaviour as follows:
- Defined: on fire, v = v_sum - threshold (subtractive soft reset).
- Undefined: on fire, v = 0 (hard reset).

Verification
REQ-036 Hard reset, leak 0 — stimulus: T_STEPS=4, threshold=10, leak_shift=0, inputs 6,6,6,6. Required response: spike_out sequence 0,1,0,1; spike_cnt=2; done pulses with the 4th spike_valid.
REQ-037 Soft reset — stimulus: LIF_SOFT_RESET_EN defined, same stimulus as REQ-036. Required response: v sequence 6,2,8,4; spike_out sequence 0,1,0,1; spike_cnt=2.
REQ-038 Leak — stimulus: threshold=100, leak_shift=1, inputs 40,40,40,40. Required response: v sequence 40,60,70,75; no spikes; spike_cnt=0.
REQ-039 Saturation — stimulus: V_WIDTH=8, threshold=255, leak_shift=0, inputs 200,200. Required response: the second step saturates v_sum to 255 and fires; spike_cnt=1.
REQ-040 Backpressure and protocol — stimulus: in_valid toggled 1,0,0,1 with start pulsed during INTEG. Required response: only valid cycles count as transfers; the extra start is ignored; busy stays 1 until DONE.
REQ-041 Reset mid-sample — stimulus: rst asserted after the 2nd transfer. Required response: all outputs go to 0 immediately; no done pulse; a new start then runs a clean sample.
